// File: rtl/led_phase_if.sv
// Bundle between the LED controller/ADC side and the phase sampler.
// The master drives LEDs, ADC and enable; the slave returns the averaged samples and status.
interface led_phase_if #(
    parameter int ADC_W = 8
);
    logic             en;
    logic [ADC_W-1:0] ADC;
    logic             LED_RED;
    logic             LED_IR;
    logic [ADC_W-1:0] red_value;
    logic             red_valid;
    logic [ADC_W-1:0] ir_value;
    logic             ir_valid;
    logic             short_phase;
    logic             phase_err;

    modport master (
        output en, ADC, LED_RED, LED_IR,
        input  red_value, red_valid, ir_value, ir_valid, short_phase, phase_err
    );

    modport slave (
        input  en, ADC, LED_RED, LED_IR,
        output red_value, red_valid, ir_value, ir_valid, short_phase, phase_err
    );
endinterface

// File: rtl/led_phase_sampler.sv
// Demultiplexes the shared ADC stream into RED and IR averages by following the LED drive.
// Each LED phase is allowed to settle, then 2^AVG_LOG2 samples are box-averaged.
module led_phase_sampler #(
    parameter int ADC_W      = 8,
    parameter int SETTLE_CYC = 2,
    parameter int AVG_LOG2   = 2
) (
    input logic        CLK,
    input logic        rst_n,
    led_phase_if.slave bus
);
    localparam int ACC_W = ADC_W + AVG_LOG2;
    localparam int CNT_W = $clog2(SETTLE_CYC + 1);
    localparam int N_W   = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [N_W-1:0]   AVG_LAST    = N_W'((1 << AVG_LOG2) - 1);

    typedef enum logic [1:0] {PH_NONE, PH_RED, PH_IR} phase_t;
    typedef enum logic [1:0] {IDLE, SETTLE, ACCUM, HOLD} state_t;

    state_t           state;
    phase_t           phase_now, phase_q, cur_phase;
    logic [CNT_W-1:0] cnt;
    logic [N_W-1:0]   n;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum;
    logic             change;
    logic [ADC_W-1:0] red_value_q, ir_value_q;
    logic             red_valid_q, ir_valid_q, short_phase_q, phase_err_q;

    // NOTE: every combinational output gets a default first so no latch can be inferred.
    always_comb begin
        phase_now = PH_NONE;
        if (bus.LED_RED && !bus.LED_IR)      phase_now = PH_RED;
        else if (bus.LED_IR && !bus.LED_RED) phase_now = PH_IR;
    end

    assign change = (phase_now != phase_q);
    assign sum    = acc + ACC_W'(bus.ADC);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            phase_q       <= PH_NONE;
            cur_phase     <= PH_NONE;
            cnt           <= '0;
            n             <= '0;
            acc           <= '0;
            red_value_q   <= '0;
            ir_value_q    <= '0;
            red_valid_q   <= 1'b0;
            ir_valid_q    <= 1'b0;
            short_phase_q <= 1'b0;
            phase_err_q   <= 1'b0;
        end else begin
            phase_q       <= phase_now;
            phase_err_q   <= bus.LED_RED & bus.LED_IR;
            red_valid_q   <= 1'b0;
            ir_valid_q    <= 1'b0;
            short_phase_q <= 1'b0;

            if (!bus.en) begin
                state <= IDLE;
                acc   <= '0;
                cnt   <= '0;
                n     <= '0;
            end else if (change) begin
                // A phase change always abandons the current average, complete or not.
                if (state == SETTLE || state == ACCUM) short_phase_q <= 1'b1;
                acc <= '0;
                cnt <= '0;
                n   <= '0;
                if (phase_now != PH_NONE) begin
                    state     <= SETTLE;
                    cur_phase <= phase_now;
                end else begin
                    state <= IDLE;
                end
            end else begin
                case (state)
                    SETTLE: begin
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == SETTLE_LAST) begin
                            state <= ACCUM;
                            acc   <= '0;
                            n     <= '0;
                        end
                    end
                    ACCUM: begin
                        acc <= sum;
                        n   <= n + N_W'(1);
                        if (n == AVG_LAST) begin
                            state <= HOLD;
                            if (cur_phase == PH_RED) begin
                                red_value_q <= sum[ACC_W-1:AVG_LOG2];
                                red_valid_q <= 1'b1;
                            end else begin
                                ir_value_q <= sum[ACC_W-1:AVG_LOG2];
                                ir_valid_q <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.red_value   = red_value_q;
    assign bus.red_valid   = red_valid_q;
    assign bus.ir_value    = ir_value_q;
    assign bus.ir_valid    = ir_valid_q;
    assign bus.short_phase = short_phase_q;
    assign bus.phase_err   = phase_err_q;
endmodule

// File: tb/tb_led_phase_sampler.sv
// Directed and randomized bench for led_phase_sampler against an age-based reference model:
// each LED run is tracked by its start edge, and strobes follow from run age and enable history.
module tb_led_phase_sampler;
    localparam int S  = 2;
    localparam int AL = 2;
    localparam int NS = 1 << AL;

    logic CLK = 1'b0;
    logic rst_n;
    always #5 CLK = ~CLK;

    led_phase_if #(.ADC_W(8)) bus ();

    led_phase_sampler #(.ADC_W(8), .SETTLE_CYC(S), .AVG_LOG2(AL)) dut (
        .CLK  (CLK),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int vectors    = 0;
    int miscompares = 0;
    int step_no    = 0;

    // Reference model: phase codes 0=none/error, 1=red, 2=ir.
    int         edge_no, prev_p, run_p, run_start, run_sum;
    bit         run_live;
    logic [7:0] exp_rvalue, exp_ivalue;
    logic       exp_rv, exp_iv, exp_sp, exp_pe;

    task automatic model_reset();
        prev_p = 0; run_p = 0; run_start = 0; run_sum = 0; run_live = 0;
        exp_rvalue = 8'd0; exp_ivalue = 8'd0;
        exp_rv = 0; exp_iv = 0; exp_sp = 0; exp_pe = 0;
    endtask

    task automatic model_edge(input bit r, input bit i, input logic [7:0] a, input bit e);
        int p, age;
        p = (r && !i) ? 1 : ((i && !r) ? 2 : 0);
        exp_rv = 0; exp_iv = 0; exp_sp = 0;
        exp_pe = r & i;
        if (!e) begin
            run_live = 0;
        end else if (p != prev_p) begin
            exp_sp    = run_live;
            run_start = edge_no;
            run_p     = p;
            run_live  = (p != 0);
            run_sum   = 0;
        end else if (run_live) begin
            age = edge_no - run_start;
            if (age > S && age <= S + NS) run_sum += int'(a);
            if (age == S + NS) begin
                if (run_p == 1) begin exp_rvalue = 8'(run_sum / NS); exp_rv = 1; end
                else            begin exp_ivalue = 8'(run_sum / NS); exp_iv = 1; end
                run_live = 0;
            end
        end
        prev_p = p;
        edge_no++;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s step=%0d observed=%0d expected=%0d", tag, step_no, obs, exp);
        end
    endtask

    task automatic check_all();
        check("red_valid",   8'(bus.red_valid),   8'(exp_rv));
        check("ir_valid",    8'(bus.ir_valid),    8'(exp_iv));
        check("red_value",   bus.red_value,       exp_rvalue);
        check("ir_value",    bus.ir_value,        exp_ivalue);
        check("short_phase", 8'(bus.short_phase), 8'(exp_sp));
        check("phase_err",   8'(bus.phase_err),   8'(exp_pe));
    endtask

    // Called at a falling edge: drive, clock once, then compare at the next falling edge.
    task automatic step(input bit r, input bit i, input logic [7:0] a, input bit e);
        bus.LED_RED = r; bus.LED_IR = i; bus.ADC = a; bus.en = e;
        @(posedge CLK);
        model_edge(r, i, a, e);
        @(negedge CLK);
        step_no++;
        check_all();
    endtask

    initial begin
        rst_n = 1'b0;
        bus.en = 1'b0; bus.ADC = 8'd0; bus.LED_RED = 1'b0; bus.LED_IR = 1'b0;
        edge_no = 0;
        model_reset();
        repeat (2) @(negedge CLK);
        check_all();
        rst_n = 1'b1;

        // Constant RED, ADC=100: strobe six edges after the change.
        for (int k = 0; k < 9; k++) step(1, 0, 8'd100, 1);
        // IR with ramp on the four sample edges: (10+11+12+13)>>2 = 11.
        for (int k = 0; k < 3; k++) step(0, 1, 8'd0, 1);
        for (int k = 0; k < 4; k++) step(0, 1, 8'(10 + k), 1);
        for (int k = 0; k < 2; k++) step(0, 1, 8'd0, 1);
        // Short RED phase followed by a complete IR phase.
        for (int k = 0; k < 4; k++) step(1, 0, 8'd50, 1);
        for (int k = 0; k < 8; k++) step(0, 1, 8'd77, 1);
        // Both LEDs on: error level, no strobes; IR afterwards samples normally.
        for (int k = 0; k < 8; k++) step(1, 1, 8'd200, 1);
        for (int k = 0; k < 8; k++) step(0, 1, 8'd33, 1);
        // Full-scale RED average must not wrap.
        for (int k = 0; k < 8; k++) step(1, 0, 8'd255, 1);
        // Enable dropped mid-SETTLE, restored while RED is still active: no strobe.
        step(0, 0, 8'd9, 1);
        step(1, 0, 8'd9, 1);
        step(1, 0, 8'd9, 0);
        for (int k = 0; k < 8; k++) step(1, 0, 8'd9, 1);
        // Change lands on the final sample edge: short_phase, no valid.
        for (int k = 0; k < S + NS; k++) step(0, 1, 8'd5, 1);
        step(1, 0, 8'd5, 1);
        for (int k = 0; k < 7; k++) step(1, 0, 8'd6, 1);

        // Reset asserted mid-ACCUM: outputs clear immediately.
        step(0, 1, 8'd40, 1);
        for (int k = 0; k < 4; k++) step(0, 1, 8'd40, 1);
        rst_n = 1'b0;
        #1;
        model_reset();
        step_no++;
        check_all();
        @(negedge CLK);
        bus.LED_IR = 1'b0;
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) step(0, 0, 8'd40, 1);

        // Randomized LED runs with occasional enable drops.
        for (int b = 0; b < 60; b++) begin
            int ph, len;
            ph  = int'($urandom_range(0, 3));
            len = int'($urandom_range(1, 10));
            for (int j = 0; j < len; j++)
                step(ph == 1 || ph == 3, ph == 2 || ph == 3, 8'($urandom_range(0, 255)),
                     $urandom_range(0, 19) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
